// File: rtl/msx_cart_pkg.sv
// Shared types and constants for the cartridge memory arbiter and its
// optional ASCII8 bank mapper.
package msx_cart_pkg;

    localparam int ADDR_W_DEF = 20;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LD_WR    = 2'd1,
        CPU_RD   = 2'd2,
        CPU_HOLD = 2'd3
    } state_e;

    // Bank select register windows, one 2 KB window per bank.
    localparam logic [3:0][15:0] ASCII8_BANK_BASE = {16'h7800, 16'h7000, 16'h6800, 16'h6000};
    localparam logic [3:0][7:0]  ASCII8_BANK_RST  = {8'd3, 8'd2, 8'd1, 8'd0};

endpackage

// File: rtl/cart_bank_regs.sv
// ASCII8 mapper: four 8 KB bank registers written through 6000-7FFF and
// translation of a Z80 read address to a physical cartridge address.
module cart_bank_regs
    import msx_cart_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_i,
    input  logic [15:0]       addr_i,
    input  logic [7:0]        din_i,
    output logic [ADDR_W-1:0] rd_addr_o
);

    logic [3:0][7:0] bank_q;
    logic [1:0]      sel;
    logic [20:0]     raw;

    // All four register windows share the top three address bits; [12:11] picks the bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bank_q <= ASCII8_BANK_RST;
        else if (wr_i && addr_i[15:13] == ASCII8_BANK_BASE[0][15:13])
            bank_q[addr_i[12:11]] <= din_i;
    end

    // 4000 -> bank0, 6000 -> bank1, 8000 -> bank2, A000 -> bank3
    assign sel       = addr_i[14:13] + 2'd2;
    assign raw       = {bank_q[sel], addr_i[12:0]};
    assign rd_addr_o = ADDR_W'(raw);

endmodule

// File: rtl/cart_mem_arbiter.sv
// Arbitrates one single-port cartridge memory between the ioctl loader and
// Z80 slot-1 reads, stretching the CPU with WAIT. ASCII8_MAPPER_EN enables banking.
module cart_mem_arbiter
    import msx_cart_pkg::*;
#(
    parameter int          ADDR_W   = ADDR_W_DEF,
    parameter logic [15:0] LIN_BASE = 16'h4000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_rd_req,
    input  logic              cpu_wr,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_wait_n,
    input  logic              ld_wr,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_busy,
    output logic              ld_overrun,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack
);

    state_e            state_q, state_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d, dout_q, dout_d;
    logic              buf_full_q, buf_full_d, ovr_q, ovr_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [7:0]        buf_data_q, buf_data_d;
    logic [ADDR_W-1:0] xl_addr;

`ifdef ASCII8_MAPPER_EN
    localparam logic [15:0] unused_lin_base = LIN_BASE;

    cart_bank_regs #(.ADDR_W(ADDR_W)) u_bank_regs (
        .clk      (clk),
        .reset    (reset),
        .wr_i     (cpu_wr),
        .addr_i   (cpu_addr),
        .din_i    (cpu_din),
        .rd_addr_o(xl_addr)
    );
`else
    logic [15:0] lin_off;
    logic        unused_cpu_wr;

    assign lin_off       = cpu_addr - LIN_BASE;
    assign xl_addr       = ADDR_W'(lin_off);
    assign unused_cpu_wr = ^{cpu_wr, cpu_din};
`endif

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        dout_d      = dout_q;
        buf_full_d  = buf_full_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
        ovr_d       = ovr_q;

        if (ld_wr) begin
            if (buf_full_q) begin
                ovr_d = 1'b1;
            end else begin
                buf_full_d = 1'b1;
                buf_addr_d = ld_addr;
                buf_data_d = ld_data;
            end
        end

        case (state_q)
            IDLE: begin
                // A loader write landing this very cycle still beats a CPU read.
                if (buf_full_q || ld_wr) begin
                    state_d     = LD_WR;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = buf_full_q ? buf_addr_q : ld_addr;
                    mem_wdata_d = buf_full_q ? buf_data_q : ld_data;
                end else if (cpu_rd_req) begin
                    state_d    = CPU_RD;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = xl_addr;
                end
            end
            LD_WR: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    buf_full_d = 1'b0;
                end
            end
            CPU_RD: begin
                if (mem_ack) begin
                    state_d   = CPU_HOLD;
                    mem_req_d = 1'b0;
                    dout_d    = mem_rdata;
                end
            end
            CPU_HOLD: begin
                if (!cpu_rd_req)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            dout_q      <= 8'hFF;
            buf_full_q  <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            dout_q      <= dout_d;
            buf_full_q  <= buf_full_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
            ovr_q       <= ovr_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_dout   = dout_q;
    assign ld_busy    = buf_full_q;
    assign ld_overrun = ovr_q;
    assign cpu_wait_n = ~(cpu_rd_req & (state_q != CPU_HOLD));

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Bench for cart_mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model with a variable-latency memory responder.
module tb_cart_mem_arbiter;

    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_rd_req, cpu_wr;
    logic [15:0]   cpu_addr;
    logic [7:0]    cpu_din, cpu_dout;
    logic          cpu_wait_n;
    logic          ld_wr;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_data;
    logic          ld_busy, ld_overrun;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata, mem_rdata;
    logic          mem_ack;

    always #5 clk = ~clk;

    cart_mem_arbiter #(.ADDR_W(AW), .LIN_BASE(16'h4000)) dut (
        .clk(clk), .reset(reset),
        .cpu_rd_req(cpu_rd_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_wait_n(cpu_wait_n),
        .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_busy(ld_busy), .ld_overrun(ld_overrun),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Backing store of the external memory; untouched locations read a hash of the address.
    logic [7:0] bench_mem [int];

    function automatic logic [7:0] rd_mem(input int a);
        if (bench_mem.exists(a)) return bench_mem[a];
        return 8'((a & 255) ^ ((a >> 8) & 255) ^ 8'h5A);
    endfunction

    // Model: one pending loader entry, the memory operation in flight, and
    // whether the current Z80 bus cycle already got its data.
    bit            m_buf, m_ovr, m_served;
    logic [AW-1:0] m_baddr, m_maddr;
    logic [7:0]    m_bdata, m_mdata, m_dout;
    int            m_op;       // 0 none, 1 loader write, 2 CPU read
    logic [7:0]    m_bank [4];

    // Memory responder
    bit            r_pend, spur_en;
    int            r_cnt, lat_fix, r_wr_acks, wl_cnt;
    int            req_log [$];
    logic [AW-1:0] addr_log [$];

    // Inputs as seen just before the active edge
    logic          p_ld_wr, p_rd, p_wr, p_ack;
    logic [AW-1:0] p_ld_addr;
    logic [7:0]    p_ld_data, p_din, p_rdata;
    logic [15:0]   p_addr;

    function automatic logic [AW-1:0] xlate(input logic [15:0] a);
`ifdef ASCII8_MAPPER_EN
        int idx = ((int'(a) >> 13) + 2) & 3;
        return AW'(int'(m_bank[idx]) * 8192 + (int'(a) & 8191));
`else
        return AW'((int'(a) - 16'h4000) & 16'hFFFF);
`endif
    endfunction

    task automatic model_reset();
        m_buf = 0; m_ovr = 0; m_served = 0; m_op = 0;
        m_dout = 8'hFF; m_baddr = '0; m_bdata = '0; m_maddr = '0; m_mdata = '0;
        for (int i = 0; i < 4; i++) m_bank[i] = 8'(i);
        r_pend = 0; r_cnt = 0; mem_ack = 0;
    endtask

    task automatic model_edge();
        int op_pre   = m_op;
        bit srv_pre  = m_served;
        bit buf_pre  = m_buf;
        bit idle_pre = (op_pre == 0) && !srv_pre;
        if (srv_pre && !p_rd) m_served = 0;
        if (p_ack && op_pre != 0) begin
            if (op_pre == 1) begin
                bench_mem[int'(m_maddr)] = m_mdata;
                m_buf = 0;
            end else begin
                m_dout   = p_rdata;
                m_served = 1;
            end
            m_op = 0;
        end
        if (p_ld_wr) begin
            if (buf_pre) m_ovr = 1;
            else begin m_buf = 1; m_baddr = p_ld_addr; m_bdata = p_ld_data; end
        end
        if (idle_pre) begin
            if (buf_pre || p_ld_wr) begin
                m_op    = 1;
                m_maddr = buf_pre ? m_baddr : p_ld_addr;
                m_mdata = buf_pre ? m_bdata : p_ld_data;
            end else if (p_rd) begin
                m_op    = 2;
                m_maddr = xlate(p_addr);
            end
        end
`ifdef ASCII8_MAPPER_EN
        if (p_wr && p_addr >= 16'h6000 && p_addr <= 16'h7FFF)
            m_bank[(int'(p_addr) - 24576) / 2048] = p_din;
`endif
    endtask

    task automatic responder();
        if (mem_req) begin
            if (!r_pend) begin
                r_pend = 1;
                r_cnt  = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 5));
                req_log.push_back(int'(mem_we));
                addr_log.push_back(mem_addr);
            end else begin
                r_cnt--;
                if (r_cnt == 0) begin
                    mem_ack   = 1;
                    mem_rdata = mem_we ? 8'($urandom) : rd_mem(int'(mem_addr));
                    if (mem_we) r_wr_acks++;
                    r_pend    = 0;
                end
            end
        end else if (spur_en && $urandom_range(0, 9) == 0) begin
            mem_ack   = 1;
            mem_rdata = 8'($urandom);
        end
    endtask

    task automatic check();
        chk("mem_req", 32'(mem_req), 32'(m_op != 0));
        if (m_op != 0) begin
            chk("mem_we", 32'(mem_we), 32'(m_op == 1));
            chk("mem_addr", 32'(mem_addr), 32'(m_maddr));
            if (m_op == 1) chk("mem_wdata", 32'(mem_wdata), 32'(m_mdata));
        end
        chk("ld_busy", 32'(ld_busy), 32'(m_buf));
        chk("ld_overrun", 32'(ld_overrun), 32'(m_ovr));
        chk("cpu_dout", 32'(cpu_dout), 32'(m_dout));
        chk("cpu_wait_n", 32'(cpu_wait_n), 32'(!(cpu_rd_req && !m_served)));
        if (!cpu_wait_n) wl_cnt++;
    endtask

    task automatic step();
        #1 check();
        p_ld_wr = ld_wr; p_ld_addr = ld_addr; p_ld_data = ld_data;
        p_rd = cpu_rd_req; p_addr = cpu_addr; p_wr = cpu_wr; p_din = cpu_din;
        p_ack = mem_ack; p_rdata = mem_rdata;
        @(posedge clk); #1;
        model_edge();
        ld_wr = 0; cpu_wr = 0; mem_ack = 0;
        responder();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_random(input int n);
        int rd_age = 0;
        spur_en = 1; lat_fix = 0;
        for (int i = 0; i < n; i++) begin
            if (!cpu_rd_req) begin
                if ($urandom_range(0, 3) == 0) begin
                    cpu_addr   = 16'h4000 + 16'($urandom_range(0, 16'h7FFF));
                    cpu_rd_req = 1;
                    rd_age     = 0;
                end else if ($urandom_range(0, 5) == 0) begin
                    cpu_addr = 16'h6000 + 16'($urandom_range(0, 16'h1FFF));
                    cpu_din  = 8'($urandom_range(0, 31));
                    cpu_wr   = 1;
                end
            end else if (m_served) begin
                if ($urandom_range(0, 1) == 0) cpu_rd_req = 0;
            end else if (++rd_age > 100) begin
                n_chk++; n_fail++;
                $display("FAIL rd_timeout: read not served after %0d cycles", rd_age);
                cpu_rd_req = 0;
            end
            if ($urandom_range(0, 7) == 0) begin
                ld_wr   = 1;
                ld_addr = AW'($urandom);
                ld_data = 8'($urandom);
            end
            step();
        end
        cpu_rd_req = 0; spur_en = 0;
        steps(20);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; cpu_rd_req = 0; cpu_wr = 0; cpu_addr = '0; cpu_din = '0;
        ld_wr = 0; ld_addr = '0; ld_data = '0; mem_rdata = '0; mem_ack = 0;
        spur_en = 0; lat_fix = 0; r_wr_acks = 0; wl_cnt = 0;
        model_reset();
        #12;
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        chk("rst_cpu_dout", 32'(cpu_dout), 32'hFF);
        chk("rst_ld_busy", 32'(ld_busy), 32'h0);
        chk("rst_ld_overrun", 32'(ld_overrun), 32'h0);
        chk("rst_wait_n", 32'(cpu_wait_n), 32'h1);
        @(negedge clk) reset = 0;
        @(posedge clk); #1;

        // Loader write, ack three cycles after the request is seen
        lat_fix = 3; ld_wr = 1; ld_addr = 20'h00010; ld_data = 8'hA5;
        begin
            int busy = 0;
            for (int i = 0; i < 10; i++) begin
                step();
                if (ld_busy) busy++;
                if (i == 0) begin
                    chk("t1_mem_we", 32'(mem_we), 32'h1);
                    chk("t1_mem_addr", 32'(mem_addr), 32'h10);
                    chk("t1_mem_wdata", 32'(mem_wdata), 32'hA5);
                end
            end
            chk("t1_busy_cycles", 32'(busy), 32'd4);
        end

        // CPU read at 4010 with latency 5
        bench_mem[16] = 8'h3C;
        lat_fix = 5; cpu_addr = 16'h4010; cpu_rd_req = 1;
        wl_cnt = 0; addr_log.delete(); req_log.delete();
        steps(12);
        chk("t2_mem_addr", 32'(addr_log[0]), 32'h10);
        chk("t2_wait_cycles", 32'(wl_cnt), 32'd7);
        chk("t2_cpu_dout", 32'(cpu_dout), 32'h3C);
        cpu_rd_req = 0; steps(2);

        // Loader write and CPU read in the same cycle
        lat_fix = 2; ld_wr = 1; ld_addr = 20'h00123; ld_data = 8'h5A;
        cpu_addr = 16'h4200; cpu_rd_req = 1;
        wl_cnt = 0; addr_log.delete(); req_log.delete();
        steps(14);
        chk("t3_n_reqs", 32'(req_log.size()), 32'd2);
        chk("t3_first_is_wr", 32'(req_log[0]), 32'd1);
        chk("t3_second_is_rd", 32'(req_log[1]), 32'd0);
        chk("t3_rd_addr", 32'(addr_log[1]), 32'h200);
        chk("t3_wait_cycles", 32'(wl_cnt), 32'd8);
        cpu_rd_req = 0; steps(2);

`ifdef ASCII8_MAPPER_EN
        cpu_wr = 1; cpu_addr = 16'h6800; cpu_din = 8'h07;
        step();
        lat_fix = 2; cpu_addr = 16'h6123; cpu_rd_req = 1;
        addr_log.delete(); req_log.delete();
        steps(6);
        chk("t_map_addr", 32'(addr_log[0]), 32'h0E123);
        cpu_rd_req = 0; steps(2);
`endif

        run_random(3000);

        // Second loader write while the first is still pending
        lat_fix = 4; r_wr_acks = 0; addr_log.delete(); req_log.delete();
        ld_wr = 1; ld_addr = 20'h00200; ld_data = 8'h11;
        step();
        ld_wr = 1; ld_addr = 20'h00300; ld_data = 8'h22;
        step();
        chk("t4_overrun", 32'(ld_overrun), 32'h1);
        steps(10);
        chk("t4_wr_count", 32'(r_wr_acks), 32'd1);
        chk("t4_wr_addr", 32'(addr_log[0]), 32'h200);

        // Reset in the middle of a CPU read, then a stale ack
        lat_fix = 5; cpu_addr = 16'h4555; cpu_rd_req = 1;
        steps(2);
        chk("t5_req_before", 32'(mem_req), 32'h1);
        reset = 1;
        model_reset();
        #1;
        chk("t5_req_dropped", 32'(mem_req), 32'h0);
        chk("t5_dout_rst", 32'(cpu_dout), 32'hFF);
        chk("t5_overrun_clr", 32'(ld_overrun), 32'h0);
        @(negedge clk);
        reset = 0; cpu_rd_req = 0; mem_ack = 1; mem_rdata = 8'h99;
        step();
        chk("t5_req_after_ack", 32'(mem_req), 32'h0);
        chk("t5_dout_after_ack", 32'(cpu_dout), 32'hFF);
        lat_fix = 2; cpu_rd_req = 1;
        #1 chk("t5_wait_low", 32'(cpu_wait_n), 32'h0);
        step();
        chk("t5_new_read", 32'({mem_req, mem_we}), 32'b10);
        steps(6);
        cpu_rd_req = 0; steps(2);

        run_random(1500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
